// File: rtl/vga_pkg.sv
// Shared VGA timing constants and pixel formats for the line-buffer path.
// The drawer and the scanout use the same RGB565 pixel type; the scanout
// widens it to 8-bit-per-channel colour with rgb565_to_888.
package vga_pkg;

  localparam int H_ACTIVE = 1280;  // active clk cycles per line (2 clk per pixel)
  localparam int H_TOTAL  = 1600;  // clk cycles per line
  localparam int V_ACTIVE = 480;   // active lines per frame
  localparam int V_TOTAL  = 525;   // lines per frame

  typedef logic [15:0] rgb565_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Bit replication: full-scale 5/6-bit values map to 8'hFF, zero maps to 0.
  function automatic rgb888_t rgb565_to_888(input rgb565_t p);
    rgb888_t c;
    c.r = {p[15:11], p[15:13]};
    c.g = {p[10:5], p[10:9]};
    c.b = {p[4:0], p[4:2]};
    return c;
  endfunction

endpackage

// File: rtl/linebuffer_scanout.sv
// Display-side reader for the double-buffered pixel line buffer.
// Scans 640 RGB565 pixels per active line (2 clk per pixel), writes BG_COLOR
// behind each read so the buffer returns clean, pulses switch at SWAP_H when
// the drawer reports draw_done, and counts lines where the drawer was late.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   hcount, vcount             VGA timing counters
//   draw_done                  drawer has finished the next line
//   switch, line_start         swap pulse and the drawer start pulse after it
//   *_pixel_display            display port of the pixel line buffer
//   *_tile_display             unused tile port, tied off
//   vga_r, vga_g, vga_b        pixel colour, 2 clk behind hcount
//   late_lines                 saturating count of missed swaps
//
// state | meaning
// SYNC  | after reset; idle until the next hcount==0 line boundary
// SCAN  | active part of a displayed line: read, then clear, each pixel
// BLANK | horizontal/vertical blank; swap decision at SWAP_H
module linebuffer_scanout
  import vga_pkg::*;
#(
  parameter int            SWAP_H   = 1590,
  parameter logic [15:0]   BG_COLOR = 16'h0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [10:0]  hcount,
  input  logic [9:0]   vcount,
  input  logic         draw_done,
  output logic         switch,
  output logic         line_start,
  output logic [9:0]   address_pixel_display,
  output logic [15:0]  data_pixel_display,
  output logic         wren_pixel_display,
  input  logic [15:0]  q_pixel_display,
  output logic [5:0]   address_tile_display,
  output logic         wren_tile_display,
  output logic [255:0] data_tile_display,
  output logic [7:0]   vga_r,
  output logic [7:0]   vga_g,
  output logic [7:0]   vga_b,
  output logic [15:0]  late_lines
);

  typedef enum logic [1:0] {SYNC, SCAN, BLANK} state_t;

  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] H_ACT_M1 = 11'(H_ACTIVE - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SWAP   = 11'(SWAP_H);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_ACT_M1 = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);

  state_t  state;
  rgb888_t pix_q;
  logic    scan_slot;
  logic    swap_slot;
  logic    next_active;

  // The RAM read port is registered, so the address has to be valid in the
  // very cycle named by hcount; it is decoded from state and hcount rather
  // than registered. SYNC already presents address 0 / wren 0 during the
  // hcount==0 cycle, which is exactly the first read of the line.
  assign scan_slot   = (state == SCAN) && (hcount < H_ACT) && !reset;
  assign swap_slot   = (state == BLANK) && (hcount == H_SWAP) && !reset;
  assign next_active = (vcount == V_LAST) || (vcount < V_ACT_M1);

  assign address_pixel_display = scan_slot ? hcount[10:1] : '0;
  assign wren_pixel_display    = scan_slot & hcount[0];
  assign data_pixel_display    = BG_COLOR;

  // Decoded so the pulse lands in the SWAP_H cycle itself.
  assign switch = swap_slot & draw_done;

  assign address_tile_display = '0;
  assign wren_tile_display    = 1'b0;
  assign data_tile_display    = '0;

  assign vga_r = pix_q.r;
  assign vga_g = pix_q.g;
  assign vga_b = pix_q.b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SYNC;
      line_start <= 1'b0;
      pix_q      <= '0;
      late_lines <= '0;
    end else begin
      line_start <= switch;

      if (swap_slot && !draw_done && next_active && (late_lines != 16'hFFFF))
        late_lines <= late_lines + 16'd1;

      // Odd scan cycle carries the read of pixel hcount/2; hold it across the
      // following even cycle, clear once the last pixel's slot has passed.
      if ((state == SCAN) && (hcount < H_ACT) && hcount[0])
        pix_q <= rgb565_to_888(q_pixel_display);
      else if (!(!hcount[0] && (hcount <= H_ACT)))
        pix_q <= '0;

      case (state)
        SYNC: begin
          if (hcount == 11'd0)
            state <= (vcount < V_ACT) ? SCAN : BLANK;
        end
        SCAN: begin
          if (hcount >= H_ACT_M1)
            state <= BLANK;
        end
        BLANK: begin
          if ((hcount == H_LAST) && next_active)
            state <= SCAN;
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_linebuffer_scanout.sv
module tb_linebuffer_scanout;
  import vga_pkg::*;

  localparam int SWAP_H = 1590;

  logic         clk = 1'b0;
  logic         reset;
  logic [10:0]  hcount;
  logic [9:0]   vcount;
  logic         draw_done;
  logic         switch;
  logic         line_start;
  logic [9:0]   address_pixel_display;
  logic [15:0]  data_pixel_display;
  logic         wren_pixel_display;
  logic [15:0]  q_pixel_display;
  logic [5:0]   address_tile_display;
  logic         wren_tile_display;
  logic [255:0] data_tile_display;
  logic [7:0]   vga_r, vga_g, vga_b;
  logic [15:0]  late_lines;

  linebuffer_scanout #(.SWAP_H(SWAP_H), .BG_COLOR(16'h0000)) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .draw_done(draw_done), .switch(switch), .line_start(line_start),
    .address_pixel_display(address_pixel_display),
    .data_pixel_display(data_pixel_display),
    .wren_pixel_display(wren_pixel_display),
    .q_pixel_display(q_pixel_display),
    .address_tile_display(address_tile_display),
    .wren_tile_display(wren_tile_display),
    .data_tile_display(data_tile_display),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .late_lines(late_lines)
  );

  always #5 clk = ~clk;

  logic [15:0] mem     [0:639];   // line buffer RAM driven by the DUT
  logic [15:0] exp_mem [0:639];   // expected buffer contents
  logic [23:0] line_vga[0:H_TOTAL-1];
  int vectors = 0;
  int miscompares = 0;
  int exp_late = 0;
  int wren_cnt, switch_cnt;
  bit in_sync, next_scan;

  function automatic logic [23:0] expand(input int p);
    int r5, g6, b5, r, g, b;
    r5 = (p >> 11) & 31;
    g6 = (p >> 5) & 63;
    b5 = p & 31;
    r = (r5 * 8) + (r5 / 4);
    g = (g6 * 4) + (g6 / 16);
    b = (b5 * 8) + (b5 / 4);
    return 24'((r << 16) | (g << 8) | b);
  endfunction

  // One clock: RAM reads pre-write contents, then applies the clear write.
  task automatic step();
    logic [9:0] a;
    logic w;
    logic [15:0] d;
    a = address_pixel_display;
    w = wren_pixel_display;
    d = data_pixel_display;
    @(posedge clk);
    #1;
    if (a < 10'd640) begin
      q_pixel_display = mem[a];
      if (w) mem[a] = d;
    end
  endtask

  task automatic run_line(input int v, input bit dd, input int rst_h);
    bit scan, nact;
    int lim;
    logic [15:0] snap[0:639];
    scan = in_sync ? (v < V_ACTIVE) : next_scan;
    nact = (v == V_TOTAL - 1) || (v < V_ACTIVE - 1);
    for (int x = 0; x < 640; x++) snap[x] = exp_mem[x];
    wren_cnt = 0;
    switch_cnt = 0;
    for (int h = 0; h < H_TOTAL; h++) begin
      bit dead, act, ew, es, el;
      int ea;
      logic [23:0] ev, got;
      hcount = 11'(h);
      vcount = 10'(v);
      draw_done = (h == SWAP_H) ? dd : 1'($urandom);
      reset = (h == rst_h);
      #1;
      dead = (rst_h >= 0) && (h > rst_h);
      act  = scan && !dead && (h != rst_h) && (h < H_ACTIVE);
      ew   = act && (h % 2 == 1);
      ea   = act ? h / 2 : 0;
      ev   = (scan && !dead && h >= 2 && h <= H_ACTIVE + 1) ? expand(int'(snap[(h - 2) / 2])) : 24'h0;
      es   = !dead && (h != rst_h) && (h == SWAP_H) && dd;
      el   = !dead && (h == SWAP_H + 1) && dd;
      got  = {vga_r, vga_g, vga_b};
      line_vga[h] = got;
      if (wren_pixel_display) wren_cnt++;
      if (switch) switch_cnt++;
      vectors++;
      if (got !== ev) begin
        miscompares++;
        $display("FAIL vga v=%0d h=%0d got %h expected %h", v, h, got, ev);
      end
      vectors++;
      if (wren_pixel_display !== ew || (ew && (address_pixel_display !== 10'(ea) ||
          data_pixel_display !== 16'h0000)) || (!ew && address_pixel_display !== 10'(ea))) begin
        miscompares++;
        $display("FAIL ram_port v=%0d h=%0d got wren=%b addr=%0d data=%h expected wren=%b addr=%0d data=0000",
                 v, h, wren_pixel_display, address_pixel_display, data_pixel_display, ew, ea);
      end
      vectors++;
      if (switch !== es || line_start !== el) begin
        miscompares++;
        $display("FAIL swap v=%0d h=%0d got switch=%b line_start=%b expected %b %b",
                 v, h, switch, line_start, es, el);
      end
      if (h == H_TOTAL - 1) begin
        vectors++;
        if (late_lines !== 16'(exp_late)) begin
          miscompares++;
          $display("FAIL late_lines v=%0d got %0d expected %0d", v, late_lines, exp_late);
        end
      end
      if (h == SWAP_H && !dead && h != rst_h && !dd && nact && exp_late < 65535) exp_late++;
      if (h == rst_h) exp_late = 0;
      step();
    end
    reset = 1'b0;
    if (scan) begin
      lim = (rst_h >= 0) ? rst_h : H_ACTIVE;
      for (int x = 0; x < 640; x++) if (2 * x + 1 < lim) exp_mem[x] = 16'h0000;
    end
    in_sync = (rst_h >= 0);
    next_scan = nact;
    begin
      int bad;
      bad = 0;
      for (int x = 0; x < 640; x++) if (mem[x] !== exp_mem[x]) bad++;
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL buffer_clear v=%0d got %0d wrong words expected 0", v, bad);
      end
    end
  endtask

  task automatic fill_random();
    for (int x = 0; x < 640; x++) begin
      mem[x] = 16'($urandom);
      exp_mem[x] = mem[x];
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hcount = 11'd700;
    vcount = 10'd5;
    draw_done = 1'b1;
    step();
    step();
    vectors++;
    if ({switch, line_start, wren_pixel_display} !== 3'b000 || address_pixel_display !== 10'd0 ||
        {vga_r, vga_g, vga_b} !== 24'h0 || late_lines !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state got sw=%b ls=%b wren=%b addr=%0d rgb=%h late=%0d expected all zero",
               switch, line_start, wren_pixel_display, address_pixel_display, {vga_r, vga_g, vga_b}, late_lines);
    end
    vectors++;
    if (address_tile_display !== 6'd0 || wren_tile_display !== 1'b0 || data_tile_display !== 256'd0) begin
      miscompares++;
      $display("FAIL tile_tieoff got addr=%0d wren=%b expected 0 0", address_tile_display, wren_tile_display);
    end
    reset = 1'b0;
    for (int h = 701; h < 704; h++) begin
      hcount = 11'(h);
      #1;
      vectors++;
      if (wren_pixel_display !== 1'b0 || switch !== 1'b0) begin
        miscompares++;
        $display("FAIL sync_idle h=%0d got wren=%b switch=%b expected 0 0", h, wren_pixel_display, switch);
      end
      step();
    end
    in_sync = 1'b1;
    exp_late = 0;
  endtask

  task automatic test_ramp_line();
    for (int x = 0; x < 640; x++) begin
      mem[x] = 16'(x);
      exp_mem[x] = 16'(x);
    end
    run_line(0, 1'b1, -1);
    vectors++;
    if (line_vga[12] !== 24'h000029 || line_vga[13] !== 24'h000029) begin
      miscompares++;
      $display("FAIL pixel5 got %h/%h expected 000029", line_vga[12], line_vga[13]);
    end
    vectors++;
    if (wren_cnt != 640 || switch_cnt != 1) begin
      miscompares++;
      $display("FAIL line_counts got wren=%0d switch=%0d expected 640 1", wren_cnt, switch_cnt);
    end
  endtask

  task automatic test_late_line();
    fill_random();
    mem[0] = 16'hFFFF; exp_mem[0] = 16'hFFFF;
    mem[1] = 16'hF800; exp_mem[1] = 16'hF800;
    run_line(10, 1'b0, -1);
    vectors++;
    if (line_vga[2] !== 24'hFFFFFF || line_vga[4] !== 24'hFF0000) begin
      miscompares++;
      $display("FAIL corner_colors got %h %h expected ffffff ff0000", line_vga[2], line_vga[4]);
    end
    vectors++;
    if (late_lines !== 16'd1 || switch_cnt != 0) begin
      miscompares++;
      $display("FAIL late_miss got late=%0d switch=%0d expected 1 0", late_lines, switch_cnt);
    end
    run_line(11, 1'b1, -1);   // drawer missed: cleared buffer shows background
  endtask

  task automatic test_vblank();
    fill_random();
    run_line(479, 1'b1, -1);
    run_line(500, 1'b0, -1);
    vectors++;
    if (late_lines !== 16'd1) begin
      miscompares++;
      $display("FAIL blank_miss got late=%0d expected 1", late_lines);
    end
    run_line(524, 1'b1, -1);
    vectors++;
    if (switch_cnt != 1) begin
      miscompares++;
      $display("FAIL vblank_swap got %0d switches expected 1", switch_cnt);
    end
  endtask

  task automatic test_midline_reset();
    fill_random();
    run_line(0, 1'b1, 700);
    run_line(1, 1'b1, -1);
    vectors++;
    if (wren_cnt != 640) begin
      miscompares++;
      $display("FAIL post_reset_scan got %0d writes expected 640", wren_cnt);
    end
  endtask

  task automatic test_saturation();
    hcount = 11'd1279;
    vcount = 10'd1;
    step();
    hcount = 11'(SWAP_H);
    vcount = 10'd10;
    draw_done = 1'b0;
    for (int i = 0; i < 65534; i++) step();
    vectors++;
    if (late_lines !== 16'hFFFE) begin
      miscompares++;
      $display("FAIL late_count got %h expected fffe", late_lines);
    end
    for (int i = 0; i < 6; i++) step();
    vectors++;
    if (late_lines !== 16'hFFFF || switch !== 1'b0) begin
      miscompares++;
      $display("FAIL late_saturate got %h switch=%b expected ffff 0", late_lines, switch);
    end
  endtask

  initial begin
    reset = 1'b1;
    hcount = '0;
    vcount = '0;
    draw_done = 1'b0;
    q_pixel_display = '0;
    for (int x = 0; x < 640; x++) begin
      mem[x] = '0;
      exp_mem[x] = '0;
    end
    test_reset();
    test_ramp_line();
    test_late_line();
    test_vblank();
    test_midline_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
